// File: rtl/bp_clint_multi.sv
// bp_clint_multi: multi-hart CLINT with per-hart msip/mtimecmp/meip, one shared mtime and a
// buffered cmd/resp channel. Define BP_CLINT_EXT_RTC_EN to advance mtime from rtc_tick_i
// instead of the internal rtc_div_p prescaler.
module bp_clint_multi #(
   parameter int unsigned num_harts_p       = 4,
   parameter int unsigned dword_width_p     = 64,
   parameter int unsigned dev_addr_width_p  = 16,
   parameter int unsigned tag_width_p       = 8,
   parameter int unsigned max_outstanding_p = 2,
   parameter int unsigned rtc_div_p         = 8
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
`ifdef BP_CLINT_EXT_RTC_EN
   input  logic                        rtc_tick_i,
`endif
   input  logic                        cmd_v_i,
   output logic                        cmd_ready_o,
   input  logic                        cmd_wr_i,
   input  logic [1:0]                  cmd_size_i,
   input  logic [dev_addr_width_p-1:0] cmd_addr_i,
   input  logic [dword_width_p-1:0]    cmd_data_i,
   input  logic [tag_width_p-1:0]      cmd_tag_i,
   output logic                        resp_v_o,
   input  logic                        resp_yumi_i,
   output logic [dword_width_p-1:0]    resp_data_o,
   output logic [tag_width_p-1:0]      resp_tag_o,
   output logic                        resp_err_o,
   output logic [num_harts_p-1:0]      software_irq_o,
   output logic [num_harts_p-1:0]      timer_irq_o,
   output logic [num_harts_p-1:0]      external_irq_o
);

   localparam int unsigned half_w = dword_width_p / 2;
   localparam int unsigned ptr_w  = $clog2(max_outstanding_p);
   localparam int unsigned cnt_w  = $clog2(max_outstanding_p + 1);

   typedef struct packed {
      logic                        wr;
      logic [1:0]                  size;
      logic [dev_addr_width_p-1:0] addr;
      logic [dword_width_p-1:0]    data;
      logic [tag_width_p-1:0]      tag;
   } cmd_t;

   cmd_t                     fifo_mem [max_outstanding_p];
   cmd_t                     head;
   logic [ptr_w-1:0]         wptr, rptr;
   logic [cnt_w-1:0]         count;
   logic                     enq, deq, full, commit;
   logic [num_harts_p-1:0]   msip_hit, cmp_hit, meip_hit;
   logic                     mtime_hit, hit, is8, hi, aligned;
   logic [dword_width_p-1:0] rd_data;
   logic [num_harts_p-1:0]   msip, meip;
   logic [dword_width_p-1:0] mtimecmp [num_harts_p];
   logic [dword_width_p-1:0] mtime;
   logic                     tick;

   function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
      return (p == ptr_w'(max_outstanding_p - 1)) ? '0 : p + ptr_w'(1);
   endfunction

   function automatic logic [dword_width_p-1:0] rd_sel(input logic [dword_width_p-1:0] r,
                                                       input logic full_w, input logic upper);
      if (full_w) return r;
      if (upper) return {{half_w{1'b0}}, r[dword_width_p-1:half_w]};
      return {{half_w{1'b0}}, r[half_w-1:0]};
   endfunction

   function automatic logic [dword_width_p-1:0] wr_merge(input logic [dword_width_p-1:0] r,
                                                         input logic [dword_width_p-1:0] d,
                                                         input logic full_w, input logic upper);
      if (full_w) return d;
      if (upper) return {d[half_w-1:0], r[half_w-1:0]};
      return {r[dword_width_p-1:half_w], d[half_w-1:0]};
   endfunction

   // A full FIFO still accepts when the head retires in the same cycle.
   assign full        = (count == cnt_w'(max_outstanding_p));
   assign cmd_ready_o = ~full | resp_yumi_i;
   assign resp_v_o    = (count != '0);
   assign enq         = cmd_v_i & cmd_ready_o;
   assign deq         = resp_yumi_i & resp_v_o;
   assign head        = fifo_mem[rptr];
   assign commit      = deq & head.wr;

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (enq) wptr <= ptr_inc(wptr);
         if (deq) rptr <= ptr_inc(rptr);
         if (enq && !deq) count <= count + cnt_w'(1);
         else if (!enq && deq) count <= count - cnt_w'(1);
      end
   end

   // FIFO storage; contents are qualified by count so need no reset
   always_ff @(posedge clk_i) begin
      if (enq) fifo_mem[wptr] <= {cmd_wr_i, cmd_size_i, cmd_addr_i, cmd_data_i, cmd_tag_i};
   end

   // Head address decode into per-register hit vectors
   always_comb begin
      msip_hit = '0;
      cmp_hit  = '0;
      meip_hit = '0;
      for (int h = 0; h < num_harts_p; h++) begin
         msip_hit[h] = (head.addr[dev_addr_width_p-1:2] == (dev_addr_width_p-2)'(h));
         cmp_hit[h]  = (head.addr[dev_addr_width_p-1:3] == (dev_addr_width_p-3)'(32'h800 + h));
         meip_hit[h] = (head.addr[dev_addr_width_p-1:2] == (dev_addr_width_p-2)'(32'h2000 + h));
      end
   end

   assign mtime_hit = (head.addr[dev_addr_width_p-1:3] == (dev_addr_width_p-3)'(32'h17ff));
   // Sub-word offsets are not decoded; they respond as unmapped.
   assign aligned   = (head.addr[1:0] == 2'b00);
   assign hit       = aligned & ((|msip_hit) | (|cmp_hit) | (|meip_hit) | mtime_hit);
   assign is8       = (head.size == 2'd3);
   assign hi        = head.addr[2];

   // Read mux over the decoded register
   always_comb begin
      rd_data = '0;
      for (int h = 0; h < num_harts_p; h++) begin
         if (msip_hit[h]) rd_data = dword_width_p'(msip[h]);
         if (cmp_hit[h])  rd_data = rd_sel(mtimecmp[h], is8, hi);
         if (meip_hit[h]) rd_data = dword_width_p'(meip[h]);
      end
      if (mtime_hit) rd_data = rd_sel(mtime, is8, hi);
   end

   assign resp_data_o = (resp_v_o & ~head.wr & hit) ? rd_data : '0;
   assign resp_tag_o  = resp_v_o ? head.tag : '0;
   assign resp_err_o  = resp_v_o & ~hit;

`ifdef BP_CLINT_EXT_RTC_EN
   assign tick = rtc_tick_i;
`else
   localparam int unsigned presc_w = (rtc_div_p > 1) ? $clog2(rtc_div_p) : 1;
   logic [presc_w-1:0] presc;

   assign tick = (presc == presc_w'(rtc_div_p - 1));

   // RTC prescaler, wraps at rtc_div_p-1
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) presc <= '0;
      else            presc <= tick ? '0 : presc + presc_w'(1);
   end
`endif

   // Register file; writes land only when the head is consumed
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         msip  <= '0;
         meip  <= '0;
         mtime <= '0;
         for (int h = 0; h < num_harts_p; h++) mtimecmp[h] <= '1;
      end else begin
         for (int h = 0; h < num_harts_p; h++) begin
            if (commit && aligned && msip_hit[h]) msip[h] <= head.data[0];
            if (commit && aligned && meip_hit[h]) meip[h] <= head.data[0];
            if (commit && aligned && cmp_hit[h])
               mtimecmp[h] <= wr_merge(mtimecmp[h], head.data, is8, hi);
         end
         // A write to mtime overrides a coincident tick.
         if (commit && aligned && mtime_hit) mtime <= wr_merge(mtime, head.data, is8, hi);
         else if (tick)                      mtime <= mtime + dword_width_p'(1);
      end
   end

   // Interrupt outputs straight from current register state
   always_comb begin
      timer_irq_o = '0;
      for (int h = 0; h < num_harts_p; h++) timer_irq_o[h] = (mtime >= mtimecmp[h]);
   end

   assign software_irq_o = msip;
   assign external_irq_o = meip;

endmodule
